thirty_two_bit_multiplier_sequencer: RTL and testbench



---
 rtl/thirty_two_bit_multiplier_sequencer_pkg.sv | 18 +
 rtl/thirty_two_bit_multiplier_sequencer_mult16.sv | 28 ++
 rtl/thirty_two_bit_multiplier_sequencer.sv | 128 ++++++++++++
 tb/tb_thirty_two_bit_multiplier_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thirty_two_bit_multiplier_sequencer_pkg.sv
// Shared types and widths for the 32x32 multiplier sequencer.
// The 64-bit product is built from four 16x16 partial products.
package thirty_two_bit_multiplier_sequencer_pkg;

   localparam int HALF_W = 16;
   localparam int OP_W   = 2 * HALF_W;
   localparam int PROD_W = 64;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MUL0 = 3'd1,
      MUL1 = 3'd2,
      MUL2 = 3'd3,
      MUL3 = 3'd4,
      DONE = 3'd5
   } state_t;

endpackage

// File: rtl/thirty_two_bit_multiplier_sequencer_mult16.sv
// Combinational 16x16 unsigned multiplier in vedic (urdhva-tiryagbhyam) form.
// It combines four 8x8 products, and the two cross terms share one adder.
module sixteen_bit_vedic_multiplier
   import thirty_two_bit_multiplier_sequencer_pkg::*;
(
   input  logic [HALF_W-1:0]   a,
   input  logic [HALF_W-1:0]   b,
   output logic [2*HALF_W-1:0] p
);

   localparam int Q = HALF_W / 2;

   logic [HALF_W-1:0] q0;
   logic [HALF_W-1:0] q1;
   logic [HALF_W-1:0] q2;
   logic [HALF_W-1:0] q3;
   logic [HALF_W:0]   mid;

   assign q0 = {{Q{1'b0}}, a[Q-1:0]}      * {{Q{1'b0}}, b[Q-1:0]};
   assign q1 = {{Q{1'b0}}, a[HALF_W-1:Q]} * {{Q{1'b0}}, b[Q-1:0]};
   assign q2 = {{Q{1'b0}}, a[Q-1:0]}      * {{Q{1'b0}}, b[HALF_W-1:Q]};
   assign q3 = {{Q{1'b0}}, a[HALF_W-1:Q]} * {{Q{1'b0}}, b[HALF_W-1:Q]};

   // The cross terms land Q bits up, over the concatenated outer terms.
   assign mid = {1'b0, q1} + {1'b0, q2};
   assign p   = {q3, q0} + {{(Q-1){1'b0}}, mid, {Q{1'b0}}};

endmodule

// File: rtl/thirty_two_bit_multiplier_sequencer.sv
// 32x32 unsigned multiplier that runs four partial products through one
// shared 16x16 multiplier. Approx mode skips the low x low term.
module thirty_two_bit_multiplier_sequencer
   import thirty_two_bit_multiplier_sequencer_pkg::*;
#(
   parameter int APPROX_SUPPORT = 1
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in1,
   input  logic [OP_W-1:0]   in2,
   input  logic              approx_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] out,
   output logic              busy
);

   state_t               state;
   logic [OP_W-1:0]      a_reg;
   logic [OP_W-1:0]      b_reg;
   logic                 approx_reg;
   logic [PROD_W-1:0]    acc;
   logic                 approx_eff;
   logic [HALF_W-1:0]    mul_a;
   logic [HALF_W-1:0]    mul_b;
   logic [2*HALF_W-1:0]  mul_p;
   logic [PROD_W-1:0]    addend;

   assign approx_eff = approx_en && (APPROX_SUPPORT != 0);
   assign out        = acc;

   sixteen_bit_vedic_multiplier u_mult16 (
      .a (mul_a),
      .b (mul_b),
      .p (mul_p)
   );

   // State selects the operand halves and the weight of the partial product.
   always_comb begin
      mul_a  = a_reg[HALF_W-1:0];
      mul_b  = b_reg[HALF_W-1:0];
      addend = {{(PROD_W-2*HALF_W){1'b0}}, mul_p};
      case (state)
         MUL0: begin
            if (approx_reg) addend = '0;
         end
         MUL1: begin
            mul_a  = a_reg[OP_W-1:HALF_W];
            addend = {{HALF_W{1'b0}}, mul_p, {HALF_W{1'b0}}};
         end
         MUL2: begin
            mul_b  = b_reg[OP_W-1:HALF_W];
            addend = {{HALF_W{1'b0}}, mul_p, {HALF_W{1'b0}}};
         end
         MUL3: begin
            mul_a  = a_reg[OP_W-1:HALF_W];
            mul_b  = b_reg[OP_W-1:HALF_W];
            addend = {mul_p, {(2*HALF_W){1'b0}}};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         a_reg      <= '0;
         b_reg      <= '0;
         approx_reg <= 1'b0;
         acc        <= '0;
         out_valid  <= 1'b0;
         in_ready   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_reg      <= in1;
                  b_reg      <= in2;
                  approx_reg <= approx_eff;
                  acc        <= '0;
                  in_ready   <= 1'b0;
                  busy       <= 1'b1;
                  state      <= approx_eff ? MUL1 : MUL0;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            MUL0: begin
               acc   <= acc + addend;
               state <= MUL1;
            end
            MUL1: begin
               acc   <= acc + addend;
               state <= MUL2;
            end
            MUL2: begin
               acc   <= acc + addend;
               state <= MUL3;
            end
            MUL3: begin
               acc       <= acc + addend;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            // acc is left untouched so out keeps the product until the next accept.
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_thirty_two_bit_multiplier_sequencer.sv
// Directed bench for the multiplier sequencer. A second instance with
// approx support disabled checks that approx_en is ignored there.
module tb_thirty_two_bit_multiplier_sequencer;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in1;
   logic [31:0] in2;
   logic        approx_en;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out;
   logic        busy;

   logic        in_valid_na;
   logic        in_ready_na;
   logic        out_valid_na;
   logic        out_ready_na;
   logic [63:0] out_na;
   logic        busy_na;

   int total;
   int bad;

   thirty_two_bit_multiplier_sequencer #(.APPROX_SUPPORT(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .approx_en (approx_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .busy      (busy)
   );

   thirty_two_bit_multiplier_sequencer #(.APPROX_SUPPORT(0)) dut_na (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_na),
      .in_ready  (in_ready_na),
      .in1       (in1),
      .in2       (in2),
      .approx_en (approx_en),
      .out_valid (out_valid_na),
      .out_ready (out_ready_na),
      .out       (out_na),
      .busy      (busy_na)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Latency counts the accept cycle as cycle 1, so exact results show up in cycle 5.
   task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic ap,
                        input bit churn, output logic [63:0] res, output int lat,
                        output time t_acc);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("[TB] FAIL issue_ready got in_ready=%0b want 1", in_ready);
      end
      in1       = x;
      in2       = y;
      approx_en = ap;
      in_valid  = 1'b1;
      @(posedge clk);
      t_acc = $time;
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         if (churn) begin
            in1       = $urandom;
            in2       = $urandom;
            approx_en = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
         end
         @(posedge clk);
         #1;
         lat++;
      end
      in_valid  = 1'b0;
      approx_en = 1'b0;
      if (!out_valid) begin
         total++;
         bad++;
         $display("[TB] FAIL issue_timeout got out_valid=%0b want 1", out_valid);
      end
      res = out;
   endtask

   task automatic finish_op();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out !== 64'd0) begin
         bad++;
         $display("[TB] FAIL reset_state got rdy=%0b vld=%0b busy=%0b out=%h want 0 0 0 0",
                  in_ready, out_valid, busy, out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_release got rdy=%0b busy=%0b want 1 0", in_ready, busy);
      end
   endtask

   task automatic test_exact_max();
      logic [63:0] res;
      int lat;
      time t;
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, res, lat, t);
      total++;
      if (res !== 64'hFFFF_FFFE_0000_0001) begin
         bad++;
         $display("[TB] FAIL exact_max got %h want fffffffe00000001", res);
      end
      total++;
      if (lat !== 5) begin
         bad++;
         $display("[TB] FAIL exact_latency got %0d want 5", lat);
      end
      total++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL done_flags got busy=%0b rdy=%0b want 1 0", busy, in_ready);
      end
      finish_op();
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL handshake got vld=%0b busy=%0b rdy=%0b want 0 0 1",
                  out_valid, busy, in_ready);
      end
      total++;
      if (out !== 64'hFFFF_FFFE_0000_0001) begin
         bad++;
         $display("[TB] FAIL out_hold_idle got %h want fffffffe00000001", out);
      end
   endtask

   task automatic test_approx();
      logic [63:0] res;
      int lat;
      time t;
      issue(32'h0001_0003, 32'h0002_0005, 1'b1, 1'b0, res, lat, t);
      total++;
      if (res !== 64'h0000_0002_000B_0000 || lat !== 4) begin
         bad++;
         $display("[TB] FAIL approx_on got %h lat=%0d want 00000002000b0000 lat=4", res, lat);
      end
      finish_op();
      issue(32'h0001_0003, 32'h0002_0005, 1'b0, 1'b0, res, lat, t);
      total++;
      if (res !== 64'h0000_0002_000B_000F || lat !== 5) begin
         bad++;
         $display("[TB] FAIL approx_off got %h lat=%0d want 00000002000b000f lat=5", res, lat);
      end
      finish_op();
   endtask

   task automatic test_backpressure();
      logic [63:0] res;
      int lat;
      time t;
      issue(32'h0001_2345, 32'h0000_0100, 1'b0, 1'b0, res, lat, t);
      total++;
      if (res !== 64'h0000_0000_0123_4500) begin
         bad++;
         $display("[TB] FAIL bp_result got %h want 0000000001234500", res);
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out !== 64'h0000_0000_0123_4500) begin
            bad++;
            $display("[TB] FAIL bp_hold cycle %0d got vld=%0b rdy=%0b out=%h want 1 0 1234500",
                     i, out_valid, in_ready, out);
         end
      end
      finish_op();
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL bp_release got vld=%0b busy=%0b rdy=%0b want 0 0 1",
                  out_valid, busy, in_ready);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [63:0] res;
      int lat;
      time t;
      @(negedge clk);
      in1       = 32'h0001_0003;
      in2       = 32'h0002_0005;
      approx_en = 1'b0;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b1 || out === 64'd0) begin
         bad++;
         $display("[TB] FAIL midop_progress got busy=%0b out=%h want busy=1 out!=0", busy, out);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || out !== 64'd0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midop_reset got vld=%0b out=%h busy=%0b rdy=%0b want 0 0 0 0",
                  out_valid, out, busy, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midop_release got rdy=%0b vld=%0b want 1 0", in_ready, out_valid);
      end
      issue(32'd7, 32'd9, 1'b0, 1'b0, res, lat, t);
      total++;
      if (res !== 64'd63 || lat !== 5) begin
         bad++;
         $display("[TB] FAIL midop_next got %0d lat=%0d want 63 lat=5", res, lat);
      end
      finish_op();
   endtask

   task automatic test_no_approx_support();
      int lat;
      @(negedge clk);
      total++;
      if (in_ready_na !== 1'b1) begin
         bad++;
         $display("[TB] FAIL na_ready got %0b want 1", in_ready_na);
      end
      in1         = 32'h0001_0003;
      in2         = 32'h0002_0005;
      approx_en   = 1'b1;
      in_valid_na = 1'b1;
      @(posedge clk);
      #1;
      in_valid_na = 1'b0;
      lat = 1;
      while (!out_valid_na && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      approx_en = 1'b0;
      total++;
      if (out_na !== 64'h0000_0002_000B_000F || lat !== 5) begin
         bad++;
         $display("[TB] FAIL na_exact got %h lat=%0d want 00000002000b000f lat=5", out_na, lat);
      end
      @(negedge clk);
      out_ready_na = 1'b1;
      @(posedge clk);
      #1;
      out_ready_na = 1'b0;
      total++;
      if (out_valid_na !== 1'b0 || busy_na !== 1'b0) begin
         bad++;
         $display("[TB] FAIL na_release got vld=%0b busy=%0b want 0 0", out_valid_na, busy_na);
      end
   endtask

   task automatic test_operand_churn();
      logic [63:0] res;
      int lat;
      time t;
      issue(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b1, res, lat, t);
      total++;
      if (res !== 64'h0000_0000_FFFE_0001) begin
         bad++;
         $display("[TB] FAIL churn_exact got %h want 00000000fffe0001", res);
      end
      finish_op();
      issue(32'hFFFF_0000, 32'h0000_1234, 1'b1, 1'b1, res, lat, t);
      total++;
      if (res !== 64'h0000_1233_EDCC_0000 || lat !== 4) begin
         bad++;
         $display("[TB] FAIL churn_approx got %h lat=%0d want 00001233edcc0000 lat=4", res, lat);
      end
      finish_op();
   endtask

   task automatic test_back_to_back();
      logic [31:0] va [6];
      logic [31:0] vb [6];
      logic        vap [6];
      logic [63:0] vexp [6];
      logic [63:0] res;
      int          lat;
      time         t;
      time         t_prev;
      va[0] = 32'h0000_0002; vb[0] = 32'h0000_0003; vap[0] = 1'b0; vexp[0] = 64'h0000_0000_0000_0006;
      va[1] = 32'h8000_0000; vb[1] = 32'h0000_0002; vap[1] = 1'b0; vexp[1] = 64'h0000_0001_0000_0000;
      va[2] = 32'h0001_0003; vb[2] = 32'h0002_0005; vap[2] = 1'b1; vexp[2] = 64'h0000_0002_000B_0000;
      va[3] = 32'hFFFF_FFFF; vb[3] = 32'h0000_0001; vap[3] = 1'b0; vexp[3] = 64'h0000_0000_FFFF_FFFF;
      va[4] = 32'h1234_5678; vb[4] = 32'h0001_0000; vap[4] = 1'b0; vexp[4] = 64'h0000_1234_5678_0000;
      va[5] = 32'hFFFF_FFFF; vb[5] = 32'hFFFF_FFFF; vap[5] = 1'b1; vexp[5] = 64'hFFFF_FFFD_0002_0000;
      t_prev = 0;
      for (int i = 0; i < 6; i++) begin
         issue(va[i], vb[i], vap[i], 1'b0, res, lat, t);
         total++;
         if (res !== vexp[i]) begin
            bad++;
            $display("[TB] FAIL b2b_result[%0d] got %h want %h", i, res, vexp[i]);
         end
         if (i > 0) begin
            total++;
            if ((t - t_prev) / 10 !== (vap[i-1] ? 5 : 6)) begin
               bad++;
               $display("[TB] FAIL b2b_interval[%0d] got %0d want %0d",
                        i, (t - t_prev) / 10, vap[i-1] ? 5 : 6);
            end
         end
         t_prev = t;
         finish_op();
      end
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      in1          = '0;
      in2          = '0;
      approx_en    = 1'b0;
      out_ready    = 1'b0;
      in_valid_na  = 1'b0;
      out_ready_na = 1'b0;
      test_reset();
      test_exact_max();
      test_approx();
      test_backpressure();
      test_reset_mid_op();
      test_no_approx_support();
      test_operand_churn();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
